// File: rtl/prv32_muldiv_pkg.sv
// prv32_muldiv_pkg: RV32M funct3 encodings, MDU FSM states and op-class helpers shared with the ALU.
// Revision: 1.0
`default_nettype none

package prv32_muldiv_pkg;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

   function automatic logic is_div_op(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/prv32_muldiv_step.sv
// prv32_muldiv_step: one radix-2 iteration on a 2*XLEN accumulator (shift-add, or restoring
// shift-subtract when PRV32_MULDIV_DIV_EN is defined). Revision: 1.0
`default_nettype none

module prv32_muldiv_step #(
   parameter int XLEN = 32
) (
`ifdef PRV32_MULDIV_DIV_EN
   input  logic                i_div,
`endif
   input  logic [2*XLEN-1:0]   i_acc,
   input  logic [XLEN-1:0]     i_opnd,
   output logic [2*XLEN-1:0]   o_acc
);

   // Multiply: {hi, multiplier} with the multiplier consumed LSB-first; the carry shifts into hi.
   logic [XLEN:0] w_sum;
   assign w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);

`ifdef PRV32_MULDIV_DIV_EN
   // Divide: {remainder, dividend}; the shifted partial remainder needs XLEN+1 bits.
   logic [XLEN:0] w_part;
   logic [XLEN:0] w_diff;
   assign w_part = i_acc[2*XLEN-1:XLEN-1];
   assign w_diff = w_part - {1'b0, i_opnd};

   always_comb begin
      if (!i_div)
         o_acc = {w_sum, i_acc[XLEN-1:1]};
      else if (w_diff[XLEN])
         o_acc = {w_part[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
      else
         o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
   end
`else
   assign o_acc = {w_sum, i_acc[XLEN-1:1]};
`endif

endmodule

`default_nettype wire

// File: rtl/prv32_muldiv.sv
// prv32_muldiv: iterative RV32M multiply/divide unit with valid/ready handshake and kill.
// Divider datapath only when PRV32_MULDIV_DIV_EN is defined. Revision: 1.0
`default_nettype none

module prv32_muldiv
   import prv32_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int             CW         = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]  c_CNT_LAST = CW'(XLEN);

   mdu_state_e        r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [XLEN-1:0]   r_result;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opnd;
   logic              r_neg;
   logic              r_bypass;

   logic              w_accept;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_neg;
   logic              w_bypass;
   logic [XLEN-1:0]   w_bypass_val;
   logic [2*XLEN-1:0] w_step_acc;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_final;

   assign w_accept = in_valid && r_in_ready && !kill;
   assign w_a_neg  = a_is_signed(op) & a[XLEN-1];
   assign w_b_neg  = b_is_signed(op) & b[XLEN-1];
   assign w_mag_a  = w_a_neg ? -a : a;
   assign w_mag_b  = w_b_neg ? -b : b;
   assign w_neg    = (op == MDU_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

   // Ops that finish without iterating carry their answer in r_acc and spend one CALC cycle.
   always_comb begin
      w_bypass     = 1'b0;
      w_bypass_val = '0;
`ifdef PRV32_MULDIV_DIV_EN
      if (is_div_op(op)) begin
         if (b == '0) begin
            w_bypass     = 1'b1;
            w_bypass_val = op[1] ? a : '1;
         end else if (((op == MDU_DIV) || (op == MDU_REM)) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
            w_bypass     = 1'b1;
            w_bypass_val = op[1] ? '0 : a;
         end
      end
`else
      if (is_div_op(op))
         w_bypass = 1'b1;
`endif
   end

   prv32_muldiv_step #(
      .XLEN   (XLEN)
   ) u_step (
`ifdef PRV32_MULDIV_DIV_EN
      .i_div  (is_div_op(r_op)),
`endif
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .o_acc  (w_step_acc)
   );

   assign w_prod = r_neg ? -r_acc : r_acc;

`ifdef PRV32_MULDIV_DIV_EN
   logic [XLEN-1:0] w_quo;
   logic [XLEN-1:0] w_rem;
   assign w_quo = r_neg ? -r_acc[XLEN-1:0]      : r_acc[XLEN-1:0];
   assign w_rem = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
`endif

   always_comb begin
      w_final = '0;
      if (r_bypass)
         w_final = r_acc[XLEN-1:0];
      else if (r_op == MDU_MUL)
         w_final = w_prod[XLEN-1:0];
`ifdef PRV32_MULDIV_DIV_EN
      else if (is_div_op(r_op))
         w_final = r_op[1] ? w_rem : w_quo;
`endif
      else
         w_final = w_prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_cnt       <= '0;
         r_op        <= MDU_MUL;
         r_acc       <= '0;
         r_opnd      <= '0;
         r_neg       <= 1'b0;
         r_bypass    <= 1'b0;
      end else if (kill) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state    <= CALC;
                  r_in_ready <= 1'b0;
                  r_op       <= op;
                  r_neg      <= w_neg;
                  r_bypass   <= w_bypass;
                  r_cnt      <= w_bypass ? c_CNT_LAST : '0;
                  if (w_bypass) begin
                     r_acc  <= {{XLEN{1'b0}}, w_bypass_val};
                     r_opnd <= '0;
                  end else if (is_div_op(op)) begin
                     r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                     r_opnd <= w_mag_b;
                  end else begin
                     r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                     r_opnd <= w_mag_a;
                  end
               end
            end
            CALC: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_state     <= DONE;
                  r_result    <= w_final;
                  r_out_valid <= 1'b1;
               end else begin
                  r_acc <= w_step_acc;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_prv32_muldiv.sv
// tb_prv32_muldiv: directed vector table plus handshake/kill sequences for prv32_muldiv (XLEN=32).
// Revision: 1.0
`default_nettype none

module tb_prv32_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   prv32_muldiv #(
      .XLEN      (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      n = 0;
      @(negedge clk);
      op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
      @(posedge clk); #1;
      chk({v.name, " in_ready after accept"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            n = i;
            break;
         end
      end
      chk({v.name, " latency"}, 32'(n), 32'(v.lat));
      chk({v.name, " result"}, result, v.exp);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({v.name, " in_ready after drain"}, {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      vecs.push_back('{"MUL 7*-3",       3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33});
      vecs.push_back('{"MULH min*min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33});
      vecs.push_back('{"MULHU max*max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
      vecs.push_back('{"MULHSU -1*max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
      vecs.push_back('{"MUL x*0",        3'd0, 32'h12345678, 32'h00000000, 32'h00000000, 33});
      vecs.push_back('{"MULHU 2^16*2^16",3'd3, 32'h00010000, 32'h00010000, 32'h00000001, 33});
      vecs.push_back('{"MULH -1*1",      3'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33});
      vecs.push_back('{"MUL 2^16*2^16",  3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 33});
`ifdef PRV32_MULDIV_DIV_EN
      vecs.push_back('{"DIV -7/2",       3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
      vecs.push_back('{"REM -7/2",       3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
      vecs.push_back('{"DIVU big/2",     3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33});
      vecs.push_back('{"REMU 100/7",     3'd7, 32'h00000064, 32'h00000007, 32'h00000002, 33});
      vecs.push_back('{"DIV 100/-7",     3'd4, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 33});
      vecs.push_back('{"REM 100/-7",     3'd6, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 33});
      vecs.push_back('{"DIVU 5/0",       3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
      vecs.push_back('{"REMU 5/0",       3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 1});
      vecs.push_back('{"DIV ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
      vecs.push_back('{"REM ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
`else
      vecs.push_back('{"DIV 10/3 nodiv", 3'd4, 32'h0000000A, 32'h00000003, 32'h00000000, 1});
      vecs.push_back('{"DIVU 10/3 nodiv",3'd5, 32'h0000000A, 32'h00000003, 32'h00000000, 1});
      vecs.push_back('{"REM 10/3 nodiv", 3'd6, 32'h0000000A, 32'h00000003, 32'h00000000, 1});
      vecs.push_back('{"REMU 10/3 nodiv",3'd7, 32'h0000000A, 32'h00000003, 32'h00000000, 1});
`endif

      // Reset asserted together with kill and a pending request.
      rst = 1'b1; kill = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      op = 3'd0; a = 32'd3; b = 32'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset result", result, 32'd0);
      rst = 1'b0; kill = 1'b0; in_valid = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: result held while out_ready is low, no re-accept on the draining edge.
      @(negedge clk);
      op = 3'd3; a = 32'h00010000; b = 32'h00030000; in_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      chk("bp out_valid seen", 32'(seen), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp hold out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp hold result", result, 32'h00000003);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
      @(posedge clk); #1;
      chk("bp drain in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp drain out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;

      // Kill in CALC cycle 10 with a new request pending.
      @(negedge clk);
      op = 3'd0; a = 32'd3; b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      kill = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
      @(posedge clk); #1;
      chk("kill calc in_ready", {31'd0, in_ready}, 32'd1);
      chk("kill calc out_valid", {31'd0, out_valid}, 32'd0);
      // Kill in IDLE beats a simultaneous request.
      @(posedge clk); #1;
      chk("kill idle no accept", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      kill = 1'b0; in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      chk("kill no out_valid", 32'(seen), 32'd0);
      chk("kill idle after", {31'd0, in_ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
